// File: rtl/seq_alu_pkg.sv
// alu_pkg: shared definitions for the seq_alu block.
//   WIDTH      - datapath width (fixed at 8)
//   OP_*       - 3-bit opcode encodings
//   state_e    - FSM state encoding (ST_MUL exists only with SEQ_ALU_MUL_EN)
//   alu_calc() - single-cycle datapath: result plus carry/borrow/shift-out
// Configuration macro: SEQ_ALU_MUL_EN
package alu_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
`ifdef SEQ_ALU_MUL_EN
    ,
    ST_MUL  = 2'd3
`endif
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
  } alu_out_t;

  // OP_MUL only reaches this function when the multiplier is not built;
  // it then acts as a pass-through of operand A.
  function automatic alu_out_t alu_calc(input logic [2:0]       op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t       r;
    logic [WIDTH:0] wide;
    r    = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow (a < b).
        wide  = {1'b0, a} - {1'b0, b};
        r.res = wide[WIDTH-1:0];
        r.c   = wide[WIDTH];
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_SHL: begin
        r.res = {a[WIDTH-2:0], 1'b0};
        r.c   = a[WIDTH-1];
      end
      OP_SHR: begin
        r.res = {1'b0, a[WIDTH-1:1]};
        r.c   = a[0];
      end
      default: begin
        r.res = a;
        r.c   = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the accumulator side and seq_alu.
//   master: drives start, op, a, b; observes result, strobes, busy and flags
//   slave : the ALU side (seq_alu)
interface seq_alu_if;
  import alu_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             load_acc;
  logic             done;
  logic             busy;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output start, op, a, b,
    input  result, load_acc, done, busy, flag_z, flag_n, flag_c
  );

  modport slave (
    input  start, op, a, b,
    output result, load_acc, done, busy, flag_z, flag_n, flag_c
  );

endinterface

// File: rtl/seq_alu_mul.sv
// shift_add_mul: 8x8 iterative shift-add multiplier (built only with
// SEQ_ALU_MUL_EN).
//   clk, reset (async, active-low)
//   go      - load operands; first iteration is performed on this edge
//   a, b    - operands, sampled only when go is high
//   busy    - high while iterations 2..8 are still pending
//   product - 16-bit product, final once busy has fallen
`ifdef SEQ_ALU_MUL_EN
module shift_add_mul
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2:0]         cnt_q,    cnt_d;
  logic               busy_q,   busy_d;

  // Iteration 1 happens on the go edge so that the eighth lands one edge
  // before the controller samples busy; cnt then counts iterations 2..8.
  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (go) begin
      prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = {1'b0, b[WIDTH-1:1]};
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 3'd1;
      if (cnt_q == 3'd6) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign product = prod_q;

endmodule
`endif

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 8-bit ALU between the accumulator and the register bus.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - seq_alu_if.slave: start/op/a/b in; result, load_acc, done,
//           busy, flag_z/n/c out
// Single-cycle ops: IDLE -> CALC -> DONE (2 clocks to the accumulator load).
// Configuration macro: SEQ_ALU_MUL_EN adds IDLE -> MUL -> DONE for op 111
// (9 clocks); without it op 111 passes operand A through.
module seq_alu
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       op_q,     op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q,      z_d;
  logic             n_q,      n_d;
  logic             c_q,      c_d;
  alu_out_t         calc;

`ifdef SEQ_ALU_MUL_EN
  logic               mul_go;
  logic               mul_busy;
  logic [2*WIDTH-1:0] mul_product;

  // Fed from the bus directly: go coincides with operand latching.
  shift_add_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .go      (mul_go),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .product (mul_product)
  );
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    calc     = alu_calc(op_q, a_q, b_q);
`ifdef SEQ_ALU_MUL_EN
    mul_go   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d  = bus.a;
          b_d  = bus.b;
          op_d = bus.op;
`ifdef SEQ_ALU_MUL_EN
          if (bus.op == OP_MUL) begin
            mul_go  = 1'b1;
            state_d = ST_MUL;
          end else begin
            state_d = ST_CALC;
          end
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        result_d = calc.res;
        c_d      = calc.c;
        z_d      = (calc.res == '0);
        n_d      = calc.res[WIDTH-1];
        state_d  = ST_DONE;
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        if (!mul_busy) begin
          result_d = mul_product[WIDTH-1:0];
          c_d      = |mul_product[2*WIDTH-1:WIDTH];
          z_d      = (mul_product[WIDTH-1:0] == '0);
          n_d      = mul_product[WIDTH-1];
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_n   = n_q;
  assign bus.flag_c   = c_q;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.load_acc = (state_q == ST_DONE);
  assign bus.busy     = (state_q != ST_IDLE);

endmodule
